bcd_clock: RTL and testbench

BCD_CLOCK -- requirements
Module: bcd_clock

---
 rtl/bcd_clock_if.sv | 28 ++
 rtl/bcd_clock.sv | 189 ++++++++++++++++++
 tb/tb_bcd_clock.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_clock_if.sv
// Bundle of the run/set/display signals between the BCD clock core and its user.
interface bcd_clock_if;
  logic       run;
  logic       mode12;
  logic       set_en;
  logic [7:0] set_hh;
  logic [7:0] set_mm;
  logic [7:0] set_ss;
  logic       set_err;
  logic       sec_tick;
  logic       pm;
  logic [6:0] seg0;
  logic [6:0] seg1;
  logic [6:0] seg2;
  logic [6:0] seg3;
  logic [6:0] seg4;
  logic [6:0] seg5;

  modport master (
    output run, mode12, set_en, set_hh, set_mm, set_ss,
    input  set_err, sec_tick, pm, seg0, seg1, seg2, seg3, seg4, seg5
  );

  modport slave (
    input  run, mode12, set_en, set_hh, set_mm, set_ss,
    output set_err, sec_tick, pm, seg0, seg1, seg2, seg3, seg4, seg5
  );
endinterface

// File: rtl/bcd_clock.sv
// Six-digit BCD time-of-day clock with prescaler, settable time and
// registered 7-segment outputs in 12- or 24-hour display form.
module bcd_clock #(
  parameter int CLK_HZ         = 50_000_000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input logic        clk,
  input logic        reset,
  bcd_clock_if.slave bus
);

  localparam int            PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [6:0]    ZERO_PAT  = SEG_ACTIVE_LOW ? 7'b0000001 : 7'b1111110;

  // Time layout: [23:20] hour tens, [19:16] hour units, [15:12] minute tens,
  // [11:8] minute units, [7:4] second tens, [3:0] second units.
  logic [PW-1:0]     presc_q, presc_d;
  logic [23:0]       time_q, time_d;
  logic              sec_tick_q, sec_tick_d;
  logic              set_err_q, set_err_d;
  logic              pm_q, pm_d;
  logic [5:0][6:0]   seg_q, seg_d;

  logic              advance;
  logic              set_legal;
  logic [4:0]        hour_bin;
  logic [4:0]        disp_hour;
  logic [3:0]        disp_tens;
  logic [3:0]        disp_units;

  // Maps a digit to its segment pattern {a..g}; blank turns every segment off.
  function automatic logic [6:0] seg_encode(input logic [3:0] digit, input logic blank);
    logic [6:0] pat;
    if (blank) begin
      pat = 7'b1111111;
    end else begin
      case (digit)
        4'd0:    pat = 7'b0000001;
        4'd1:    pat = 7'b1001111;
        4'd2:    pat = 7'b0010010;
        4'd3:    pat = 7'b0000110;
        4'd4:    pat = 7'b1001100;
        4'd5:    pat = 7'b0100100;
        4'd6:    pat = 7'b0100000;
        4'd7:    pat = 7'b0001111;
        4'd8:    pat = 7'b0000000;
        4'd9:    pat = 7'b0000100;
        default: pat = 7'b1111111;
      endcase
    end
    return SEG_ACTIVE_LOW ? pat : ~pat;
  endfunction

  // A load value is usable only if it is valid BCD and names a real time of day.
  function automatic logic bcd_legal(input logic [7:0] hh, input logic [7:0] mm,
                                     input logic [7:0] ss);
    logic ok;
    ok = (hh[7:4] <= 4'd2) && (hh[3:0] <= 4'd9) &&
         (mm[7:4] <= 4'd5) && (mm[3:0] <= 4'd9) &&
         (ss[7:4] <= 4'd5) && (ss[3:0] <= 4'd9) &&
         !((hh[7:4] == 4'd2) && (hh[3:0] > 4'd3));
    return ok;
  endfunction

  // One-second BCD increment with carries rippling from seconds up to hours.
  function automatic logic [23:0] time_inc(input logic [23:0] t);
    logic [23:0] r;
    r = t;
    if (t[3:0] != 4'd9) begin
      r[3:0] = t[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (t[7:4] != 4'd5) begin
        r[7:4] = t[7:4] + 4'd1;
      end else begin
        r[7:4] = 4'd0;
        if (t[11:8] != 4'd9) begin
          r[11:8] = t[11:8] + 4'd1;
        end else begin
          r[11:8] = 4'd0;
          if (t[15:12] != 4'd5) begin
            r[15:12] = t[15:12] + 4'd1;
          end else begin
            r[15:12] = 4'd0;
            if (t[23:16] == 8'h23) begin
              r[23:16] = 8'h00;
            end else if (t[19:16] == 4'd9) begin
              r[19:16] = 4'd0;
              r[23:20] = t[23:20] + 4'd1;
            end else begin
              r[19:16] = t[19:16] + 4'd1;
            end
          end
        end
      end
    end
    return r;
  endfunction

  assign advance   = bus.run && (presc_q == PRESC_MAX);
  assign set_legal = bcd_legal(bus.set_hh, bus.set_mm, bus.set_ss);

  // Next time/prescaler: a legal set beats a coincident advance, an illegal one only flags.
  always_comb begin
    presc_d    = presc_q;
    time_d     = time_q;
    sec_tick_d = 1'b0;
    set_err_d  = 1'b0;
    if (bus.run) begin
      presc_d = advance ? '0 : presc_q + PW'(1);
    end
    if (advance) begin
      time_d     = time_inc(time_q);
      sec_tick_d = 1'b1;
    end
    if (bus.set_en) begin
      if (set_legal) begin
        time_d     = {bus.set_hh, bus.set_mm, bus.set_ss};
        presc_d    = '0;
        sec_tick_d = 1'b0;
      end else begin
        set_err_d  = 1'b1;
      end
    end
  end

  // Display next-state from the current time registers and the display mode.
  always_comb begin
    hour_bin   = 5'(time_q[23:20]) * 5'd10 + 5'(time_q[19:16]);
    disp_hour  = hour_bin;
    disp_tens  = 4'd0;
    disp_units = 4'd0;
    seg_d      = seg_q;
    pm_d       = (hour_bin >= 5'd12);
    if (bus.mode12) begin
      if (hour_bin == 5'd0) begin
        disp_hour = 5'd12;
      end else if (hour_bin > 5'd12) begin
        disp_hour = hour_bin - 5'd12;
      end
    end
    if (disp_hour >= 5'd20) begin
      disp_tens  = 4'd2;
      disp_units = 4'(disp_hour - 5'd20);
    end else if (disp_hour >= 5'd10) begin
      disp_tens  = 4'd1;
      disp_units = 4'(disp_hour - 5'd10);
    end else begin
      disp_units = 4'(disp_hour);
    end
    seg_d[0] = seg_encode(time_q[3:0],   1'b0);
    seg_d[1] = seg_encode(time_q[7:4],   1'b0);
    seg_d[2] = seg_encode(time_q[11:8],  1'b0);
    seg_d[3] = seg_encode(time_q[15:12], 1'b0);
    seg_d[4] = seg_encode(disp_units,    1'b0);
    seg_d[5] = seg_encode(disp_tens,     bus.mode12 && (disp_tens == 4'd0));
  end

  // State and output registers, all cleared immediately by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q    <= '0;
      time_q     <= '0;
      sec_tick_q <= 1'b0;
      set_err_q  <= 1'b0;
      pm_q       <= 1'b0;
      seg_q      <= {6{ZERO_PAT}};
    end else begin
      presc_q    <= presc_d;
      time_q     <= time_d;
      sec_tick_q <= sec_tick_d;
      set_err_q  <= set_err_d;
      pm_q       <= pm_d;
      seg_q      <= seg_d;
    end
  end

  assign bus.sec_tick = sec_tick_q;
  assign bus.set_err  = set_err_q;
  assign bus.pm       = pm_q;
  assign bus.seg0     = seg_q[0];
  assign bus.seg1     = seg_q[1];
  assign bus.seg2     = seg_q[2];
  assign bus.seg3     = seg_q[3];
  assign bus.seg4     = seg_q[4];
  assign bus.seg5     = seg_q[5];

endmodule

// File: tb/tb_bcd_clock.sv
// Self-checking bench for bcd_clock: directed scenarios plus random traffic,
// compared each cycle against a seconds-of-day reference model.
module tb_bcd_clock;

  localparam int CLK_HZ = 4;

  logic clk = 1'b0;
  logic reset;

  bcd_clock_if bus();

  bcd_clock #(.CLK_HZ(CLK_HZ), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;

  int          m_secs;
  int          m_presc;
  logic        m_tick;
  logic        m_err;
  logic        m_pm;
  logic [41:0] m_segs;

  function automatic logic [6:0] digit_pattern(input int d);
    case (d)
      0:       return 7'b0000001;
      1:       return 7'b1001111;
      2:       return 7'b0010010;
      3:       return 7'b0000110;
      4:       return 7'b1001100;
      5:       return 7'b0100100;
      6:       return 7'b0100000;
      7:       return 7'b0001111;
      8:       return 7'b0000000;
      9:       return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected {seg5..seg0} for a given second of the day and display mode.
  function automatic logic [41:0] display_model(input int secs, input logic m12);
    int h, m, s, dh;
    logic [6:0] tens_pat;
    h  = secs / 3600;
    m  = (secs / 60) % 60;
    s  = secs % 60;
    dh = h;
    if (m12) begin
      if (h == 0) dh = 12;
      else if (h > 12) dh = h - 12;
    end
    tens_pat = (m12 && dh < 10) ? 7'b1111111 : digit_pattern(dh / 10);
    return {tens_pat, digit_pattern(dh % 10), digit_pattern(m / 10),
            digit_pattern(m % 10), digit_pattern(s / 10), digit_pattern(s % 10)};
  endfunction

  function automatic bit legal_model(input logic [7:0] hh, input logic [7:0] mm,
                                     input logic [7:0] ss);
    if (hh[7:4] > 9 || hh[3:0] > 9 || mm[7:4] > 9 || mm[3:0] > 9 ||
        ss[7:4] > 9 || ss[3:0] > 9)
      return 1'b0;
    return (int'(hh[7:4]) * 10 + int'(hh[3:0]) < 24) &&
           (int'(mm[7:4]) * 10 + int'(mm[3:0]) < 60) &&
           (int'(ss[7:4]) * 10 + int'(ss[3:0]) < 60);
  endfunction

  function automatic int bcd_secs(input logic [7:0] hh, input logic [7:0] mm,
                                  input logic [7:0] ss);
    return (int'(hh[7:4]) * 10 + int'(hh[3:0])) * 3600 +
           (int'(mm[7:4]) * 10 + int'(mm[3:0])) * 60 +
           (int'(ss[7:4]) * 10 + int'(ss[3:0]));
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks_total++;
    if (observed === expected) checks_passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
  endtask

  task automatic check_all();
    checkOutput("sec_tick", 64'(bus.sec_tick), 64'(m_tick));
    checkOutput("set_err",  64'(bus.set_err),  64'(m_err));
    checkOutput("pm",       64'(bus.pm),       64'(m_pm));
    checkOutput("segs", 64'({bus.seg5, bus.seg4, bus.seg3, bus.seg2, bus.seg1, bus.seg0}),
                64'(m_segs));
  endtask

  task automatic model_reset();
    m_secs  = 0;
    m_presc = 0;
    m_tick  = 1'b0;
    m_err   = 1'b0;
    m_pm    = 1'b0;
    m_segs  = {6{digit_pattern(0)}};
  endtask

  // Drives one clock cycle of inputs, advances the model, then checks after the edge.
  task automatic applyStimulus(input logic run_i, input logic mode_i, input logic set_i,
                               input logic [7:0] hh, input logic [7:0] mm,
                               input logic [7:0] ss);
    bit adv, legal;
    bus.run    = run_i;
    bus.mode12 = mode_i;
    bus.set_en = set_i;
    bus.set_hh = hh;
    bus.set_mm = mm;
    bus.set_ss = ss;
    m_segs = display_model(m_secs, mode_i);
    m_pm   = (m_secs / 3600) >= 12;
    adv    = run_i && (m_presc == CLK_HZ - 1);
    legal  = legal_model(hh, mm, ss);
    m_err  = set_i && !legal;
    m_tick = 1'b0;
    if (set_i && legal) begin
      m_secs  = bcd_secs(hh, mm, ss);
      m_presc = 0;
    end else begin
      if (run_i) m_presc = adv ? 0 : m_presc + 1;
      if (adv) begin
        m_secs = (m_secs + 1) % 86400;
        m_tick = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(input int n, input logic run_i, input logic mode_i);
    for (int i = 0; i < n; i++) applyStimulus(run_i, mode_i, 1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  // Reset held across one edge while the given inputs try to run and set.
  task automatic hold_reset(input logic run_i, input logic set_i, input logic [7:0] mm);
    bus.run    = run_i;
    bus.mode12 = 1'b0;
    bus.set_en = set_i;
    bus.set_hh = 8'h12;
    bus.set_mm = mm;
    bus.set_ss = 8'h00;
    reset = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    check_all();
    reset = 1'b0;
    bus.set_en = 1'b0;
  endtask

  // Short reset pulse between edges; outputs must clear before the next edge.
  task automatic reset_pulse();
    reset = 1'b1;
    #2;
    model_reset();
    check_all();
    reset = 1'b0;
  endtask

  initial begin
    bus.run = 1'b0; bus.mode12 = 1'b0; bus.set_en = 1'b0;
    bus.set_hh = 8'h00; bus.set_mm = 8'h00; bus.set_ss = 8'h00;
    reset = 1'b1;
    model_reset();
    hold_reset(1'b0, 1'b0, 8'h00);

    // Three ticks from reset, then seconds units shows '3'.
    idle(12, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    checkOutput("seg0_three", 64'(bus.seg0), 64'(7'b0000110));

    // Full-carry wrap from 23:59:59.
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h23, 8'h59, 8'h59);
    idle(6, 1'b1, 1'b0);
    checkOutput("wrap_segs", 64'({bus.seg5, bus.seg4, bus.seg3, bus.seg2, bus.seg1, bus.seg0}),
                64'({6{7'b0000001}}));
    checkOutput("wrap_pm", 64'(bus.pm), 64'(0));

    // Illegal loads are rejected.
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h10, 8'h60, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h10, 8'h00, 8'h0A);
    idle(2, 1'b0, 1'b0);

    // Legal set coinciding with an advance wins; then an illegal one on an advance.
    for (int i = 0; i < CLK_HZ && m_presc != CLK_HZ - 1; i++) idle(1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h07, 8'h30, 8'h15);
    idle(5, 1'b1, 1'b0);
    for (int i = 0; i < CLK_HZ && m_presc != CLK_HZ - 1; i++) idle(1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h24, 8'h00, 8'h00);
    idle(2, 1'b1, 1'b0);

    // 12-hour display at 00, 09 and 13 hours.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
    idle(1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h09, 8'h00, 8'h00);
    idle(1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h13, 8'h00, 8'h00);
    idle(1, 1'b0, 1'b1);
    checkOutput("h13_tens_blank", 64'(bus.seg5), 64'(7'b1111111));
    checkOutput("h13_units_one",  64'(bus.seg4), 64'(7'b1001111));
    checkOutput("h13_pm",         64'(bus.pm),   64'(1));
    idle(1, 1'b0, 1'b0);

    // Pause mid-count, resume, then an async reset pulse.
    idle(2, 1'b1, 1'b0);
    idle(10, 1'b0, 1'b0);
    idle(6, 1'b1, 1'b0);
    reset_pulse();
    idle(5, 1'b1, 1'b0);

    // Reset held over an edge with a pending illegal set and a running count.
    idle(2, 1'b1, 1'b0);
    hold_reset(1'b1, 1'b1, 8'h77);
    idle(5, 1'b1, 1'b0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      logic r, m, s;
      logic [7:0] hh, mm, ss;
      r = ($urandom_range(0, 9) != 0);
      m = bus.mode12;
      if ($urandom_range(0, 19) == 0) m = ~m;
      s = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 1) == 0) begin
        hh = to_bcd($urandom_range(0, 23));
        mm = to_bcd($urandom_range(0, 59));
        ss = to_bcd($urandom_range(0, 59));
      end else begin
        hh = 8'($urandom);
        mm = 8'($urandom);
        ss = 8'($urandom);
      end
      if ($urandom_range(0, 299) == 0) reset_pulse();
      else applyStimulus(r, m, s, hh, mm, ss);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
